// File: rtl/fft_seq_pkg.sv
// Shared types and defaults for the iterative FFT sequencer.
// Holds the FSM state enum and the default log2 of the largest FFT size.
package fft_seq_pkg;

   localparam int LOG2_MAX_DEF = 10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and a runtime rollover value.
// Ports: clk, reset (async high), clear_i, count_enable_i,
//        rollover_val_i -> count_o, at_max_o (count_o == rollover_val_i).
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_i,
   input  logic                    count_enable_i,
   input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
   output logic [NUM_CNT_BITS-1:0] count_o,
   output logic                    at_max_o
);

   logic [NUM_CNT_BITS-1:0] count_q;
   logic [NUM_CNT_BITS-1:0] count_d;

   assign at_max_o = (count_q == rollover_val_i);
   assign count_o  = count_q;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_enable_i) begin
         count_d = at_max_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fft_iter_seq.sv
// Iteration/stage sequencer for an in-place radix-2 FFT engine.
// Ports: clk, reset, start, abort, cfg_log2_points, iteration_strobe ->
//        busy, stage_strobe, done, cfg_error, iteration_count_out,
//        stage_count_out, twiddle_addr (combinational from the counts).
module fft_iter_seq
   import fft_seq_pkg::*;
#(
   parameter  int LOG2_MAX = LOG2_MAX_DEF,
   localparam int IW       = LOG2_MAX - 1,
   localparam int SW       = $clog2(LOG2_MAX)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [SW:0]   cfg_log2_points,
   input  logic          iteration_strobe,
   output logic          busy,
   output logic          stage_strobe,
   output logic          done,
   output logic          cfg_error,
   output logic [IW-1:0] iteration_count_out,
   output logic [SW-1:0] stage_count_out,
   output logic [IW-1:0] twiddle_addr
);

   localparam logic [SW:0] LMIN = (SW+1)'(2);
   localparam logic [SW:0] LMAX = (SW+1)'(LOG2_MAX);

   state_e        state_q, state_d;
   logic [SW:0]   l_q, l_d;
   logic [SW-1:0] stage_q, stage_d;
   logic          busy_q, busy_d;
   logic          ss_q, ss_d;
   logic          done_q, done_d;
   logic          cerr_q, cerr_d;

   logic          cnt_clr;
   logic          cnt_en;
   logic          at_max;
   logic [IW-1:0] iter;
   logic [IW-1:0] roll;
   logic [IW:0]   pw;

   logic          is_idle;
   logic          is_run;
   logic          cfg_ok;
   logic          wrap;
   logic          last_stage;

   assign is_idle    = (state_q == S_IDLE);
   assign is_run     = (state_q == S_RUN);
   assign cfg_ok     = (cfg_log2_points >= LMIN) &&
                       (cfg_log2_points <= LMAX);
   assign cnt_en     = is_run & iteration_strobe & ~abort;
   assign wrap       = cnt_en & at_max;
   assign last_stage = ({1'b0, stage_q} == (l_q - 1'b1));

   // Group count per stage is 2^(L-1); the extra bit keeps L=LOG2_MAX exact.
   assign pw      = (IW+1)'(1) << (l_q - 1'b1);
   assign roll    = IW'(pw - 1'b1);
   assign cnt_clr = abort | ~is_run;

   flex_counter #(
      .NUM_CNT_BITS(IW)
   ) u_iter_cnt (
      .clk           (clk),
      .reset         (reset),
      .clear_i       (cnt_clr),
      .count_enable_i(cnt_en),
      .rollover_val_i(roll),
      .count_o       (iter),
      .at_max_o      (at_max)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         l_q     <= LMAX;
         stage_q <= '0;
         busy_q  <= 1'b0;
         ss_q    <= 1'b0;
         done_q  <= 1'b0;
         cerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         stage_q <= stage_d;
         busy_q  <= busy_d;
         ss_q    <= ss_d;
         done_q  <= done_d;
         cerr_q  <= cerr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: if (start && cfg_ok) state_d = S_RUN;
            S_RUN:  if (wrap && last_stage) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_d  = (state_d != S_IDLE);
      ss_d    = wrap;
      done_d  = wrap & last_stage;
      cerr_d  = is_idle & start & ~abort & ~cfg_ok;
      l_d     = l_q;
      stage_d = stage_q;
      if (is_idle && start && !abort && cfg_ok) begin
         l_d = cfg_log2_points;
      end
      if (abort || !is_run) begin
         stage_d = '0;
      end else if (wrap && !last_stage) begin
         stage_d = stage_q + 1'b1;
      end
   end

   logic [IW-1:0] mask;
   logic [SW:0]   sh;

   // Keep the low s bits of the group index and scale into the ROM range.
   assign mask         = (IW'(1) << stage_q) - 1'b1;
   assign sh           = l_q - 1'b1 - {1'b0, stage_q};
   assign twiddle_addr = (iter & mask) << sh;

   assign busy                = busy_q;
   assign stage_strobe        = ss_q;
   assign done                = done_q;
   assign cfg_error           = cerr_q;
   assign iteration_count_out = iter;
   assign stage_count_out     = stage_q;

endmodule

// File: tb/tb_fft_iter_seq.sv
// Self-checking bench for fft_iter_seq: table of runs plus corner cases.
// Expected per-cycle outputs are queued when driven and compared after the edge.
module tb_fft_iter_seq;

   localparam int LM = 10;
   localparam int IW = 9;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [SW:0]   cfg;
   logic          strobe;
   logic          busy;
   logic          stage_strobe;
   logic          done;
   logic          cfg_error;
   logic [IW-1:0] iter_o;
   logic [SW-1:0] stage_o;
   logic [IW-1:0] twiddle_addr;

   fft_iter_seq #(.LOG2_MAX(LM)) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .abort              (abort),
      .cfg_log2_points    (cfg),
      .iteration_strobe   (strobe),
      .busy               (busy),
      .stage_strobe       (stage_strobe),
      .done               (done),
      .cfg_error          (cfg_error),
      .iteration_count_out(iter_o),
      .stage_count_out    (stage_o),
      .twiddle_addr       (twiddle_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit busy;
      bit ss;
      bit dn;
      bit ce;
      int it;
      int st;
      int tw;
   } exp_t;

   typedef struct {
      int cfg;
      int n;
      bit gap;
      int start_at;
      int exp_p;
   } vec_t;

   exp_t sbq[$];
   vec_t vecs[7];
   int   checks;
   int   errors;

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic int tw_of(int L, int s, int it);
      return ((it % (1 << s)) << (L - 1 - s)) & ((1 << IW) - 1);
   endfunction

   function automatic exp_t idle_rec();
      exp_t e;
      e.busy = 0; e.ss = 0; e.dn = 0; e.ce = 0;
      e.it = 0; e.st = 0; e.tw = 0;
      return e;
   endfunction

   // Model derived from total strobes k taken in this run.
   function automatic exp_t mk(int L, int k, bit sb);
      exp_t e;
      int half = 1 << (L - 1);
      int total = L * half;
      e.busy = 1;
      e.ce = 0;
      if (k >= total) begin
         e.st = L - 1;
         e.it = 0;
      end else begin
         e.st = k / half;
         e.it = k % half;
      end
      e.ss = sb && (k > 0) && (k % half == 0);
      e.dn = sb && (k == total);
      e.tw = tw_of(L, e.st, e.it);
      return e;
   endfunction

   task automatic cyc(bit st, bit ab, bit sb, int c);
      start  = st;
      abort  = ab;
      strobe = sb;
      cfg    = 5'(c);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pop_cmp(string tag);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", tag);
         return;
      end
      checks--;
      e = sbq.pop_front();
      chk({tag, ".busy"}, busy, e.busy);
      chk({tag, ".stage_strobe"}, stage_strobe, e.ss);
      chk({tag, ".done"}, done, e.dn);
      chk({tag, ".cfg_error"}, cfg_error, e.ce);
      chk({tag, ".iter"}, iter_o, e.it);
      chk({tag, ".stage"}, stage_o, e.st);
      chk({tag, ".twiddle"}, twiddle_addr, e.tw);
   endtask

   task automatic start_run(int c);
      sbq.push_back(mk(c, 0, 0));
      cyc(1, 0, 0, c);
      pop_cmp("start");
   endtask

   task automatic strobes(int L, int k0, int k1, bit gap,
                          int start_at, output int pulses);
      pulses = 0;
      for (int k = k0; k <= k1; k++) begin
         if (gap && (k % 3 == 0)) begin
            sbq.push_back(mk(L, k - 1, 0));
            cyc(0, 0, 0, 0);
            pop_cmp("gap");
         end
         sbq.push_back(mk(L, k, 1));
         if (k == start_at) cyc(1, 0, 1, 3);
         else cyc(0, 0, 1, 0);
         if (stage_strobe === 1'b1) pulses++;
         pop_cmp("strb");
         if (L == 5 && k == 38) chk("tw_s2_i6", twiddle_addr, 8);
         if (L == 5 && k == 77) chk("tw_s4_i13", twiddle_addr, 13);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int p;
      int tot;
      int bad[4];
      vecs[0] = '{5, 16, 0, 0, 1};
      vecs[1] = '{5, 80, 0, 0, 5};
      vecs[2] = '{3, 12, 0, 0, 3};
      vecs[3] = '{10, 5120, 0, 0, 10};
      vecs[4] = '{2, 4, 1, 0, 2};
      vecs[5] = '{4, 20, 1, 0, 2};
      vecs[6] = '{5, 33, 0, 4, 2};
      bad = '{1, 11, 0, 31};
      checks = 0;
      errors = 0;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      strobe = 1'b0;
      cfg = '0;
      #1;
      chk("rst.busy", busy, 0);
      chk("rst.twiddle", twiddle_addr, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sbq.push_back(idle_rec());
      cyc(0, 0, 0, 0);
      pop_cmp("post_reset");

      foreach (vecs[i]) begin
         start_run(vecs[i].cfg);
         strobes(vecs[i].cfg, 1, vecs[i].n, vecs[i].gap,
                 vecs[i].start_at, p);
         chk($sformatf("pulses_v%0d", i), p, vecs[i].exp_p);
         tot = vecs[i].cfg << (vecs[i].cfg - 1);
         sbq.push_back(idle_rec());
         if (vecs[i].n == tot) begin
            cyc(0, 0, 0, 0);
            pop_cmp("after_done");
         end else begin
            cyc(0, 1, 0, 0);
            pop_cmp("abort_end");
         end
      end

      foreach (bad[i]) begin
         exp_t e;
         e = idle_rec();
         e.ce = 1;
         sbq.push_back(e);
         cyc(1, 0, 0, bad[i]);
         pop_cmp($sformatf("cfg_err%0d", bad[i]));
         sbq.push_back(idle_rec());
         cyc(0, 0, 0, 0);
         pop_cmp("cfg_err_clear");
      end

      sbq.push_back(idle_rec());
      cyc(1, 1, 0, 5);
      pop_cmp("start_abort");
      sbq.push_back(idle_rec());
      cyc(0, 0, 1, 0);
      pop_cmp("idle_strobe");

      start_run(5);
      strobes(5, 1, 47, 0, 0, p);
      sbq.push_back(idle_rec());
      cyc(0, 1, 1, 0);
      pop_cmp("abort_wrap");
      sbq.push_back(idle_rec());
      cyc(0, 0, 1, 0);
      pop_cmp("abort_wrap_idle");

      start_run(5);
      strobes(5, 1, 23, 0, 0, p);
      chk("pre_rst.twiddle", twiddle_addr, 8);
      reset = 1'b1;
      #1;
      chk("mid_rst.busy", busy, 0);
      chk("mid_rst.iter", iter_o, 0);
      chk("mid_rst.stage", stage_o, 0);
      chk("mid_rst.twiddle", twiddle_addr, 0);
      chk("mid_rst.ss", stage_strobe, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      start_run(3);
      strobes(3, 1, 12, 0, 0, p);
      chk("post_rst_pulses", p, 3);
      sbq.push_back(idle_rec());
      cyc(0, 0, 0, 0);
      pop_cmp("post_rst_idle");

      chk("sbq_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_iter_seq.md
FFT_ITER_SEQ -- requirements
Module: fft_iter_seq

Interface
REQ-001 The block SHALL have parameter LOG2_MAX, default 10, meaning log2 of the largest supported FFT size.
REQ-002 The block SHALL derive localparams IW = LOG2_MAX-1 (iteration width) and SW = $clog2(LOG2_MAX) (stage width).
REQ-003 The block SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  begin a transform, IDLE only.
- abort  in  1  cancel the run, return to IDLE.
- cfg_log2_points  in  SW+1  log2 of the transform size, sampled on start.
- iteration_strobe  in  1  one butterfly group completed.
- busy  out  1  high in RUN and DONE.
- stage_strobe  out  1  one-cycle pulse at the end of each stage.
- done  out  1  one-cycle pulse after the last stage.
- cfg_error  out  1  one-cycle pulse on start with an illegal cfg.
- iteration_count_out  out  IW  group index within the current stage.
- stage_count_out  out  SW  current stage index.
- twiddle_addr  out  IW  twiddle ROM index for the current group.

Function
REQ-004 The block SHALL implement the states IDLE, RUN and DONE; every output SHALL be registered except twiddle_addr.
REQ-005 In IDLE, start with 2 <= cfg_log2_points <= LOG2_MAX SHALL latch L = cfg_log2_points, clear both counts and enter RUN on the next edge.
REQ-006 In IDLE, start with an illegal cfg SHALL pulse cfg_error for one cycle and stay in IDLE.
REQ-007 In RUN, iteration_strobe SHALL increment iteration_count_out by 1 on the next edge.
REQ-008 In RUN, an iteration_strobe while iteration_count_out == 2^(L-1)-1 SHALL, on the next edge, wrap iteration_count_out to 0 and pulse stage_strobe.
REQ-009 On that wrap, if stage_count_out < L-1, stage_count_out SHALL increment.
REQ-010 On that wrap, if stage_count_out == L-1, stage_count_out SHALL hold and the state SHALL go to DONE.
REQ-011 DONE SHALL last exactly one cycle with done=1; in that cycle stage_strobe SHALL have been 1 in the same cycle as done; the state SHALL then return to IDLE with the counts cleared.
REQ-012 Latency: stage_strobe and done SHALL assert exactly one cycle after the sampled strobe edge.
REQ-013 twiddle_addr SHALL equal (iteration_count_out mod 2^s) << (L-1-s), where s = stage_count_out, truncated to IW bits.
REQ-014 iteration_strobe in IDLE or DONE SHALL be ignored.
REQ-015 start in RUN or DONE SHALL be ignored, and the latched L SHALL not change during a run.
REQ-016 abort SHALL be checked first in every state: it SHALL return the block to IDLE with the counts cleared and no stage_strobe or done pulse, even when it coincides with a wrapping strobe.
REQ-017 When start and abort assert together in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-019 reset SHALL asynchronously force IDLE, L=LOG2_MAX and all registered outputs to 0 (twiddle_addr then evaluates to 0).
REQ-020 Reset mid-run SHALL discard all progress, and the first start after reset SHALL behave exactly as from power-up.

Structure
REQ-021 Package fft_seq_pkg SHALL hold the state enum typedef and the default LOG2_MAX constant.
REQ-022 The iteration counter SHALL be a flex_counter instance with NUM_CNT_BITS=IW and a runtime rollover value of 2^(L-1)-1.
REQ-023 The stage counter, FSM and twiddle logic SHALL stay in fft_iter_seq.
REQ-024 The RTL SHALL be 120-400 lines.

Verification
REQ-025 cfg=5, start, 16 strobes -> stage_strobe once, stage_count_out=1, iteration_count_out=0.
REQ-026 cfg=5, 80 strobes -> 5 stage_strobe pulses, done one cycle after the 80th strobe, busy low the cycle after.
REQ-027 cfg=3, 12 back-to-back strobes -> stage_strobe after strobes 4, 8 and 12, done with the third; cfg=10 -> 512 strobes per stage.
REQ-028 cfg=5, stage 2, iteration 6 -> twiddle_addr=8; stage 0 -> always 0; stage 4, iteration 13 -> 13.
REQ-029 cfg=1 or cfg=11 on start -> cfg_error pulse, busy stays 0; start during RUN ignored.
REQ-030 abort on the wrapping strobe of stage 2 -> no stage_strobe, IDLE next cycle; reset mid-run -> all outputs 0 immediately, without a clock edge.
